ecg_sample_ingress: RTL and testbench

- Sits directly downstream of the test/stimulus controller. Consumes its aligned cfg and ecg enable/data streams.
- Captures the leading configuration words into registers.
- Conditions each ECG sample: DC-offset removal with saturation, plus a window-boundary tag.
- Buffers samples in a FIFO and presents them to the feature extractor over a valid/ready interface. Reports stream status.

---
 rtl/ecg_sample_ingress.sv | 160 ++++++++++++++++
 tb/tb_ecg_sample_ingress.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_sample_ingress.sv
// ECG sample ingress: captures leading config words, removes DC offset with
// saturation, tags window boundaries and queues samples for the feature extractor.
module ecg_sample_ingress #(
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int LOG2_FIFO    = 4,
    parameter int LOG2_CFG_MEM = 10,
    parameter int WIN_W        = 13,
    parameter int DEF_WIN_LEN  = 250
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_en_i,
    input  logic [DATA_W-1:0]       cfg_data_i,
    input  logic                    ecg_en_i,
    input  logic [DATA_W-1:0]       ecg_data_i,
    input  logic                    test_done_i,
    input  logic                    smp_ready_i,
    output logic                    smp_valid_o,
    output logic [DATA_W-1:0]       smp_data_o,
    output logic                    smp_last_o,
    output logic [DATA_W-1:0]       dc_offset_o,
    output logic [WIN_W-1:0]        win_len_o,
    output logic [LOG2_CFG_MEM-1:0] cfg_cnt_o,
    output logic                    ovf_o,
    output logic                    proto_err_o,
    output logic                    done_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_CFG, ST_RUN, ST_DONE} state_t;

    localparam logic [LOG2_FIFO:0] FULL_CNT = (LOG2_FIFO+1)'(FIFO_DEPTH);

    state_t                  state_reg, state_next;
    logic                    cfg_take, smp_take, order_err;

    logic [DATA_W-1:0]       dc_offset_reg;
    logic [WIN_W-1:0]        win_len_reg;
    logic [LOG2_CFG_MEM-1:0] cfg_cnt_reg;
    logic [WIN_W-1:0]        win_cnt_reg;
    logic                    stage_valid_reg, stage_last_reg;
    logic [DATA_W-1:0]       stage_data_reg;
    logic                    ovf_reg, proto_err_reg, done_reg;

    logic [DATA_W:0]         fifo_mem [FIFO_DEPTH];
    logic [LOG2_FIFO-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [LOG2_FIFO:0]      count_reg;

    logic                    fifo_empty, fifo_full, pop, push;
    logic [DATA_W:0]         diff;
    logic [DATA_W-1:0]       diff_sat;
    logic                    win_last;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (cfg_en_i) state_next = ST_CFG;
            ST_CFG:  if (ecg_en_i) state_next = ST_RUN;
            ST_RUN:  if (test_done_i && !stage_valid_reg && fifo_empty) state_next = ST_DONE;
            default: state_next = ST_DONE;
        endcase
    end

    // Per-state decode of which stream inputs are honoured or flagged
    always_comb begin
        cfg_take  = 1'b0;
        smp_take  = 1'b0;
        order_err = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cfg_take  = cfg_en_i;
                order_err = ecg_en_i;
            end
            ST_CFG: begin
                cfg_take = cfg_en_i;
                smp_take = ecg_en_i;
            end
            ST_RUN: begin
                smp_take  = ecg_en_i;
                order_err = cfg_en_i;
            end
            default: order_err = cfg_en_i | ecg_en_i;
        endcase
    end

    // Offset removal at DATA_W+1 bits; overflow shows as the top two bits disagreeing
    always_comb begin
        diff = {ecg_data_i[DATA_W-1], ecg_data_i} - {dc_offset_reg[DATA_W-1], dc_offset_reg};
        if (diff[DATA_W] != diff[DATA_W-1])
            diff_sat = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            diff_sat = diff[DATA_W-1:0];
    end

    assign win_last   = (win_len_reg != '0) && (win_cnt_reg == win_len_reg - WIN_W'(1));
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_CNT);
    assign pop        = !fifo_empty && smp_ready_i;
    assign push       = stage_valid_reg && (!fifo_full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dc_offset_reg   <= '0;
            win_len_reg     <= WIN_W'(DEF_WIN_LEN);
            cfg_cnt_reg     <= '0;
            win_cnt_reg     <= '0;
            stage_valid_reg <= 1'b0;
            stage_last_reg  <= 1'b0;
            stage_data_reg  <= '0;
            ovf_reg         <= 1'b0;
            proto_err_reg   <= 1'b0;
            done_reg        <= 1'b0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
        end else begin
            if (cfg_take) begin
                if (cfg_cnt_reg == LOG2_CFG_MEM'(0)) dc_offset_reg <= cfg_data_i;
                if (cfg_cnt_reg == LOG2_CFG_MEM'(1)) win_len_reg   <= cfg_data_i[WIN_W-1:0];
                if (cfg_cnt_reg != '1)               cfg_cnt_reg   <= cfg_cnt_reg + 1'b1;
            end
            stage_valid_reg <= smp_take;
            if (smp_take) begin
                stage_data_reg <= diff_sat;
                stage_last_reg <= win_last;
                win_cnt_reg    <= win_last ? '0 : win_cnt_reg + 1'b1;
            end
            if (stage_valid_reg && fifo_full && !pop) ovf_reg <= 1'b1;
            if (order_err) proto_err_reg <= 1'b1;
            done_reg <= (state_reg == ST_DONE);
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
        end
    end

    // Storage carries no reset; the head is masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= {stage_last_reg, stage_data_reg};
    end

    assign smp_valid_o = !fifo_empty;
    assign smp_data_o  = fifo_empty ? '0 : fifo_mem[rd_ptr_reg][DATA_W-1:0];
    assign smp_last_o  = fifo_empty ? 1'b0 : fifo_mem[rd_ptr_reg][DATA_W];
    assign dc_offset_o = dc_offset_reg;
    assign win_len_o   = win_len_reg;
    assign cfg_cnt_o   = cfg_cnt_reg;
    assign ovf_o       = ovf_reg;
    assign proto_err_o = proto_err_reg;
    assign done_o      = done_reg;

endmodule

// File: tb/tb_ecg_sample_ingress.sv
// Bench for ecg_sample_ingress: directed scenarios plus randomized streams,
// checked every cycle against a queue-based reference of the ingress behaviour.
module tb_ecg_sample_ingress;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_en, ecg_en, test_done, smp_ready;
    logic [15:0] cfg_data, ecg_data;
    logic        smp_valid_o, smp_last_o, ovf_o, proto_err_o, done_o;
    logic [15:0] smp_data_o, dc_offset_o;
    logic [12:0] win_len_o;
    logic [9:0]  cfg_cnt_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    // reference model: phase 0=IDLE 1=CFG 2=RUN 3=DONE
    int          m_ph, m_wl, m_wc, m_cnt;
    logic [15:0] m_dc;
    bit          m_ovf, m_perr, m_done, m_stg_v, m_stg_last;
    logic [15:0] m_stg_data;
    logic [16:0] m_q[$];
    logic [16:0] out_log[$];

    ecg_sample_ingress dut (
        .clk(clk), .reset(reset),
        .cfg_en_i(cfg_en), .cfg_data_i(cfg_data),
        .ecg_en_i(ecg_en), .ecg_data_i(ecg_data),
        .test_done_i(test_done), .smp_ready_i(smp_ready),
        .smp_valid_o(smp_valid_o), .smp_data_o(smp_data_o), .smp_last_o(smp_last_o),
        .dc_offset_o(dc_offset_o), .win_len_o(win_len_o), .cfg_cnt_o(cfg_cnt_o),
        .ovf_o(ovf_o), .proto_err_o(proto_err_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // DUT-side record of every handshake; ready is stable at the falling edge
    always @(negedge clk) begin
        if (!reset && smp_valid_o && smp_ready) begin
            out_log.push_back({smp_last_o, smp_data_o});
            $display("txn pop data=%h last=%b", smp_data_o, smp_last_o);
        end
    end

    task automatic model_reset();
        m_ph = 0; m_wl = 250; m_wc = 0; m_cnt = 0; m_dc = '0;
        m_ovf = 0; m_perr = 0; m_done = 0; m_stg_v = 0; m_stg_last = 0; m_stg_data = '0;
        m_q.delete();
    endtask

    task automatic model_edge();
        int old_ph, old_qn, d;
        bit old_stg, pop, acc, sl;
        old_ph = m_ph; old_stg = m_stg_v; old_qn = m_q.size();
        pop = (old_qn != 0) && smp_ready;
        if (pop) void'(m_q.pop_front());
        if (old_stg) begin
            if (old_qn < 16 || pop) m_q.push_back({m_stg_last, m_stg_data});
            else m_ovf = 1;
        end
        acc = ecg_en && (old_ph == 1 || old_ph == 2);
        if (acc) begin
            d = int'($signed(ecg_data)) - int'($signed(m_dc));
            if (d > 32767) d = 32767;
            if (d < -32768) d = -32768;
            sl = (m_wl != 0) && (m_wc == m_wl - 1);
            m_wc = sl ? 0 : (m_wc + 1) % 8192;
            m_stg_data = d[15:0];
            m_stg_last = sl;
        end
        m_stg_v = acc;
        if (cfg_en && old_ph <= 1) begin
            if (m_cnt == 0) m_dc = cfg_data;
            else if (m_cnt == 1) m_wl = int'(cfg_data & 16'h1FFF);
            if (m_cnt < 1023) m_cnt++;
        end
        if ((ecg_en && (old_ph == 0 || old_ph == 3)) || (cfg_en && old_ph >= 2)) m_perr = 1;
        m_done = (old_ph == 3);
        case (old_ph)
            0: if (cfg_en) m_ph = 1;
            1: if (ecg_en) m_ph = 2;
            2: if (test_done && !old_stg && old_qn == 0) m_ph = 3;
            default: m_ph = 3;
        endcase
    endtask

    task automatic compare_all();
        chk_eq("valid", smp_valid_o, m_q.size() != 0);
        if (smp_valid_o && m_q.size() != 0) begin
            chk_eq("data", smp_data_o, m_q[0][15:0]);
            chk_eq("last", smp_last_o, m_q[0][16]);
        end
        chk_eq("ovf", ovf_o, m_ovf);
        chk_eq("proto_err", proto_err_o, m_perr);
        chk_eq("cfg_cnt", cfg_cnt_o, m_cnt);
        chk_eq("dc_offset", dc_offset_o, m_dc);
        chk_eq("win_len", win_len_o, m_wl);
        chk_eq("done", done_o, m_done);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        cfg_en = 0; cfg_data = '0; ecg_en = 0; ecg_data = '0; test_done = 0; smp_ready = 0;
    endtask

    // Asserted off the clock edge: outputs must clear without waiting for clk
    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        #2;
        model_reset();
        chk_eq("rst_valid", smp_valid_o, 0);
        chk_eq("rst_data", smp_data_o, 0);
        chk_eq("rst_last", smp_last_o, 0);
        chk_eq("rst_ovf", ovf_o, 0);
        chk_eq("rst_proto", proto_err_o, 0);
        chk_eq("rst_done", done_o, 0);
        chk_eq("rst_dc", dc_offset_o, 0);
        chk_eq("rst_cnt", cfg_cnt_o, 0);
        chk_eq("rst_winlen", win_len_o, 250);
        #2;
        reset = 1'b0;
        out_log.delete();
    endtask

    task automatic send_cfg(input logic [15:0] w);
        cfg_en = 1; cfg_data = w; cycle(); cfg_en = 0;
    endtask

    task automatic send_smp(input logic [15:0] v);
        ecg_en = 1; ecg_data = v; cycle(); ecg_en = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        clear_inputs();
        do_reset();

        // Config then ECG with window length 4
        send_cfg(16'h0064); send_cfg(16'h0004); send_cfg(16'h1234);
        smp_ready = 1;
        for (int i = 0; i < 8; i++) send_smp(16'(100 + i));
        idle(4);
        chk_eq("t1_count", out_log.size(), 8);
        for (int i = 0; i < 8 && i < out_log.size(); i++) begin
            chk_eq("t1_data", out_log[i][15:0], i);
            chk_eq("t1_last", out_log[i][16], (i % 4) == 3);
        end
        chk_eq("t1_cfg_cnt", cfg_cnt_o, 3);
        chk_eq("t1_win_len", win_len_o, 4);

        // Saturation in both directions
        do_reset();
        smp_ready = 1;
        send_cfg(16'h7FFF); send_smp(16'h8000); idle(1);
        chk_eq("sat_neg", smp_data_o, 16'h8000);
        idle(2);
        do_reset();
        smp_ready = 1;
        send_cfg(16'h8000); send_smp(16'h7FFF); idle(1);
        chk_eq("sat_pos", smp_data_o, 16'h7FFF);
        idle(2);

        // Backpressure: 20 samples into a 16-entry FIFO
        do_reset();
        send_cfg(16'h0000); send_cfg(16'h0004);
        for (int i = 0; i < 20; i++) send_smp(16'(1000 + i));
        idle(2);
        chk_eq("bp_ovf", ovf_o, 1);
        smp_ready = 1;
        idle(20);
        chk_eq("bp_count", out_log.size(), 16);
        for (int i = 0; i < 16 && i < out_log.size(); i++) begin
            chk_eq("bp_data", out_log[i][15:0], 1000 + i);
            chk_eq("bp_last", out_log[i][16], (i % 4) == 3);
        end

        // Full FIFO with a push and pop on the same edge
        do_reset();
        send_cfg(16'h0000);
        for (int i = 0; i < 17; i++) send_smp(16'(i));
        smp_ready = 1; cycle(); smp_ready = 0;
        idle(2);
        chk_eq("fp_ovf", ovf_o, 0);
        // Mid-stream reset with a full queue
        do_reset();
        chk_eq("fp_after_rst", out_log.size(), 0);

        // Order errors
        smp_ready = 1;
        send_smp(16'h0042); idle(3);
        chk_eq("oe_idle_proto", proto_err_o, 1);
        chk_eq("oe_idle_out", out_log.size(), 0);
        send_cfg(16'h0010);
        chk_eq("oe_still_idle", cfg_cnt_o, 1);
        do_reset();
        smp_ready = 1;
        send_cfg(16'h0010); send_smp(16'h0020); idle(1);
        chk_eq("oe_run_clean", proto_err_o, 0);
        send_cfg(16'h0777); idle(1);
        chk_eq("oe_run_proto", proto_err_o, 1);
        chk_eq("oe_run_dc", dc_offset_o, 16'h0010);

        // Drain and done
        do_reset();
        send_cfg(16'h0000);
        for (int i = 0; i < 3; i++) send_smp(16'(i));
        idle(2);
        smp_ready = 1; test_done = 1;
        for (int i = 0; i < 30 && !done_o; i++) cycle();
        chk_eq("dd_done", done_o, 1);
        chk_eq("dd_count", out_log.size(), 3);
        send_smp(16'h0005);
        chk_eq("dd_proto", proto_err_o, 1);

        // Randomized streams
        for (int r = 0; r < 10; r++) begin
            int ncfg;
            do_reset();
            if ($urandom_range(0, 3) == 0) send_smp(16'($urandom));
            ncfg = $urandom_range(1, 4);
            for (int c = 0; c < ncfg; c++) begin
                if (c == 1) send_cfg(16'($urandom_range(0, 6)));
                else send_cfg(16'($urandom));
            end
            for (int i = 0; i < 80; i++) begin
                ecg_en    = ($urandom_range(0, 2) != 0);
                ecg_data  = 16'($urandom);
                smp_ready = ($urandom_range(0, 3) != 0);
                cfg_en    = ($urandom_range(0, 24) == 0);
                cfg_data  = 16'($urandom);
                cycle();
            end
            clear_inputs();
            smp_ready = 1; test_done = 1;
            idle(25);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
